// File: rtl/pll_mon_pkg.sv
// Shared types and default parameters for the PLL lock monitor and its
// helper blocks.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_HOLD_RST = 2'd2,
    ST_LOCKED   = 2'd3
  } pll_mon_state_t;

  localparam int PLL_MON_LOCK_WINDOW   = 16;
  localparam int PLL_MON_UNLOCK_FILTER = 4;
  localparam int PLL_MON_RST_HOLD      = 8;
  localparam int PLL_MON_CNT_W         = 8;

  // Bits needed to hold 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer with synchronous active-low reset, for bringing
// asynchronous PLL status lines into the PLL output clock domain.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Qualifies the raw PLL lock flag into a filtered lock, a downstream reset,
// and saturating counters of lock losses and tolerated lock glitches.
//
// state       | meaning
// UNLOCKED    | no lock; waiting for the synchronized flag to go high
// ACQUIRE     | flag high, counting the qualification window
// HOLD_RST    | lock declared, downstream reset still held low
// LOCKED      | lock declared, downstream reset released
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int LOCK_WINDOW   = PLL_MON_LOCK_WINDOW,
  parameter int UNLOCK_FILTER = PLL_MON_UNLOCK_FILTER,
  parameter int RST_HOLD      = PLL_MON_RST_HOLD,
  parameter int CNT_W         = PLL_MON_CNT_W
) (
  input  logic             inclk0,
  input  logic             reset_n,
  input  logic             locked_raw,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             rst_out_n,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int WIN_W  = cnt_width(LOCK_WINDOW);
  localparam int HOLD_W = cnt_width(RST_HOLD);
  localparam int LOW_W  = cnt_width(UNLOCK_FILTER);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOCK_WINDOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(UNLOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic sync;

  pll_lock_sync u_sync (
    .clk_i   (inclk0),
    .rst_n_i (reset_n),
    .d_i     (locked_raw),
    .q_o     (sync)
  );

  pll_mon_state_t    state_q;
  logic [WIN_W-1:0]  win_q;
  logic [HOLD_W-1:0] hold_q;
  logic [LOW_W-1:0]  low_q;
  logic              locked_q;
  logic              rst_out_n_q;
  logic              lock_lost_q;
  logic [CNT_W-1:0]  loss_cnt_q;
  logic [CNT_W-1:0]  loss_cnt_d;
  logic [CNT_W-1:0]  glitch_cnt_q;
  logic [CNT_W-1:0]  glitch_cnt_d;

  logic in_filter;
  logic loss_evt;
  logic glitch_evt;

  // A clear that coincides with an event keeps that event, so it loads 1.
  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cur,
                                                input logic             evt,
                                                input logic             clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = evt ? CNT_W'(1) : '0;
    end else if (evt && (cur != CNT_MAX)) begin
      nxt = cur + CNT_W'(1);
    end
    return nxt;
  endfunction

  assign in_filter  = (state_q == ST_HOLD_RST) || (state_q == ST_LOCKED);
  assign loss_evt   = in_filter && !sync && (low_q == LOW_LAST);
  assign glitch_evt = in_filter && sync && (low_q != '0);

  assign loss_cnt_d   = sat_next(loss_cnt_q, loss_evt, clear_cnt);
  assign glitch_cnt_d = sat_next(glitch_cnt_q, glitch_evt, clear_cnt);

  always_ff @(posedge inclk0) begin
    if (!reset_n) begin
      state_q     <= ST_UNLOCKED;
      win_q       <= '0;
      hold_q      <= '0;
      low_q       <= '0;
      locked_q    <= 1'b0;
      rst_out_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= loss_evt;
      case (state_q)
        // win_q is zero in UNLOCKED, so a window of 1 goes straight to HOLD_RST.
        ST_UNLOCKED, ST_ACQUIRE: begin
          if (!sync) begin
            state_q <= ST_UNLOCKED;
            win_q   <= '0;
          end else if (win_q == WIN_LAST) begin
            state_q  <= ST_HOLD_RST;
            win_q    <= '0;
            hold_q   <= '0;
            low_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            state_q <= ST_ACQUIRE;
            win_q   <= win_q + WIN_W'(1);
          end
        end
        ST_HOLD_RST, ST_LOCKED: begin
          if (loss_evt) begin
            state_q     <= ST_UNLOCKED;
            hold_q      <= '0;
            low_q       <= '0;
            locked_q    <= 1'b0;
            rst_out_n_q <= 1'b0;
          end else begin
            low_q <= sync ? '0 : low_q + LOW_W'(1);
            // The hold keeps running through a tolerated glitch.
            if (state_q == ST_HOLD_RST) begin
              if (hold_q == HOLD_LAST) begin
                state_q     <= ST_LOCKED;
                hold_q      <= '0;
                rst_out_n_q <= 1'b1;
              end else begin
                hold_q <= hold_q + HOLD_W'(1);
              end
            end
          end
        end
        default: state_q <= ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge inclk0) begin
    if (!reset_n) begin
      loss_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      loss_cnt_q   <= loss_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign rst_out_n  = rst_out_n_q;
  assign lock_lost  = lock_lost_q;
  assign loss_cnt   = loss_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor; expectations are queued per edge
// number when stimulus is applied and checked as each edge passes.
module tb_pll_lock_monitor;

  localparam int LW    = 16;
  localparam int UF    = 4;
  localparam int RH    = 8;
  localparam int CW    = 4;

  localparam int SIG_LOCKED = 0;
  localparam int SIG_RSTN   = 1;
  localparam int SIG_LOST   = 2;
  localparam int SIG_LOSS   = 3;
  localparam int SIG_GLITCH = 4;

  logic          clk;
  logic          reset_n;
  logic          locked_raw;
  logic          clear_cnt;
  logic          locked;
  logic          rst_out_n;
  logic          lock_lost;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] glitch_cnt;

  pll_lock_monitor #(
    .LOCK_WINDOW   (LW),
    .UNLOCK_FILTER (UF),
    .RST_HOLD      (RH),
    .CNT_W         (CW)
  ) dut (
    .inclk0     (clk),
    .reset_n    (reset_n),
    .locked_raw (locked_raw),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .rst_out_n  (rst_out_n),
    .lock_lost  (lock_lost),
    .loss_cnt   (loss_cnt),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   lost_seen = 0;
  int   exp_loss  = 0;
  int   exp_glitch = 0;

  function automatic logic [7:0] get_sig(input int s);
    case (s)
      SIG_LOCKED: return {7'd0, locked};
      SIG_RSTN:   return {7'd0, rst_out_n};
      SIG_LOST:   return {7'd0, lock_lost};
      SIG_LOSS:   return {4'd0, loss_cnt};
      SIG_GLITCH: return {4'd0, glitch_cnt};
      default:    return 8'hxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_exp(input int at, input int sig, input int val, input string tag);
    exp_t e;
    e.at  = at;
    e.sig = sig;
    e.val = 8'(val);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, then retire due expectations.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (lock_lost === 1'b1) lost_seen++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, get_sig(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int b, j, k, g, r;

  initial begin
    reset_n    = 1'b0;
    locked_raw = 1'b0;
    clear_cnt  = 1'b0;

    // Reset values
    ticks(3);
    check("rst_locked", {7'd0, locked}, 8'd0);
    check("rst_rstn",   {7'd0, rst_out_n}, 8'd0);
    check("rst_lost",   {7'd0, lock_lost}, 8'd0);
    check("rst_loss",   {4'd0, loss_cnt}, 8'd0);
    check("rst_glitch", {4'd0, glitch_cnt}, 8'd0);

    // Lock from reset release with the raw flag high from edge k
    reset_n    = 1'b1;
    locked_raw = 1'b1;
    k = cyc + 1;
    push_exp(k + LW,          SIG_LOCKED, 0, "acq_locked_early");
    push_exp(k + LW + 1,      SIG_LOCKED, 1, "acq_locked_rise");
    push_exp(k + LW + RH,     SIG_RSTN,   0, "acq_rstn_early");
    push_exp(k + LW + RH + 1, SIG_RSTN,   1, "acq_rstn_rise");
    ticks(28);
    check("acq_no_lost", 8'(lost_seen), 8'd0);
    check("acq_loss",    {4'd0, loss_cnt}, 8'd0);
    check("acq_glitch",  {4'd0, glitch_cnt}, 8'd0);

    // Three-edge low run while locked is tolerated as a glitch
    locked_raw = 1'b0;
    g = cyc + 1;
    for (int i = 0; i <= 8; i++) push_exp(g + i, SIG_LOCKED, 1, "gl_locked_held");
    push_exp(g + 4, SIG_GLITCH, exp_glitch, "gl_cnt_before");
    exp_glitch++;
    push_exp(g + 5, SIG_GLITCH, exp_glitch, "gl_cnt_after");
    push_exp(g + 5, SIG_LOST,   0, "gl_no_lost");
    push_exp(g + 8, SIG_RSTN,   1, "gl_rstn_held");
    push_exp(g + 8, SIG_LOSS,   exp_loss, "gl_loss");
    ticks(3);
    locked_raw = 1'b1;
    ticks(6);

    // Four-edge low run is a declared loss, then relock with a full window
    locked_raw = 1'b0;
    j = cyc + 1;
    push_exp(j + UF,     SIG_LOCKED, 1, "loss_locked_before");
    push_exp(j + UF,     SIG_LOST,   0, "loss_lost_before");
    push_exp(j + UF,     SIG_LOSS,   exp_loss, "loss_cnt_before");
    exp_loss++;
    push_exp(j + UF + 1, SIG_LOCKED, 0, "loss_locked_drop");
    push_exp(j + UF + 1, SIG_RSTN,   0, "loss_rstn_drop");
    push_exp(j + UF + 1, SIG_LOST,   1, "loss_pulse");
    push_exp(j + UF + 1, SIG_LOSS,   exp_loss, "loss_cnt_after");
    push_exp(j + UF + 2, SIG_LOST,   0, "loss_pulse_end");
    ticks(8);
    check("loss_pulses", 8'(lost_seen), 8'd1);
    locked_raw = 1'b1;
    k = cyc + 1;
    push_exp(k + LW,          SIG_LOCKED, 0, "relock_early");
    push_exp(k + LW + 1,      SIG_LOCKED, 1, "relock_rise");
    push_exp(k + LW + RH + 1, SIG_RSTN,   1, "relock_rstn");
    ticks(27);

    // Drop lock, then an interrupted window must restart from scratch
    locked_raw = 1'b0;
    j = cyc + 1;
    exp_loss++;
    push_exp(j + UF + 1, SIG_LOSS, exp_loss, "drop_loss_cnt");
    ticks(8);
    b = cyc + 1;
    for (int i = 0; i <= 30; i++) push_exp(b + i, SIG_LOCKED, 0, "win_restart_low");
    push_exp(b + 36, SIG_LOCKED, 0, "win_restart_early");
    push_exp(b + 37, SIG_LOCKED, 1, "win_restart_rise");
    push_exp(b + 37, SIG_LOSS,   exp_loss, "win_loss_same");
    push_exp(b + 37, SIG_GLITCH, exp_glitch, "win_glitch_same");
    push_exp(b + 44, SIG_RSTN,   0, "win_rstn_early");
    push_exp(b + 45, SIG_RSTN,   1, "win_rstn_rise");
    locked_raw = 1'b1;
    ticks(10);
    locked_raw = 1'b0;
    ticks(10);
    locked_raw = 1'b1;
    ticks(27);

    // Repeated losses, many from HOLD_RST, drive the loss counter to saturation
    for (int n = 0; n < 17; n++) begin
      locked_raw = 1'b1;
      ticks(19);
      locked_raw = 1'b0;
      j = cyc + 1;
      exp_loss = (exp_loss < 15) ? exp_loss + 1 : 15;
      push_exp(j + UF + 1, SIG_LOSS, exp_loss, "sat_loss_cnt");
      push_exp(j + UF + 1, SIG_LOST, 1, "sat_lost_pulse");
      push_exp(j + UF + 1, SIG_RSTN, 0, "sat_rstn_low");
      ticks(6);
    end
    check("sat_loss_max", {4'd0, loss_cnt}, 8'd15);

    // Clear zeroes both counters
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    exp_loss = 0;
    exp_glitch = 0;
    check("clr_loss",   {4'd0, loss_cnt}, 8'(exp_loss));
    check("clr_glitch", {4'd0, glitch_cnt}, 8'(exp_glitch));

    // Clear on the same edge as a loss loads 1
    locked_raw = 1'b1;
    ticks(19);
    locked_raw = 1'b0;
    ticks(UF + 1);
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    exp_loss = 1;
    check("clr_evt_loss", {4'd0, loss_cnt}, 8'(exp_loss));
    check("clr_evt_lost", {7'd0, lock_lost}, 8'd1);
    check("clr_evt_glitch", {4'd0, glitch_cnt}, 8'd0);

    // One-edge reset while locked with the flag high
    locked_raw = 1'b1;
    ticks(28);
    check("pre_rst_locked", {7'd0, locked}, 8'd1);
    reset_n = 1'b0;
    r = cyc + 1;
    tick();
    reset_n = 1'b1;
    check("mid_rst_locked", {7'd0, locked}, 8'd0);
    check("mid_rst_rstn",   {7'd0, rst_out_n}, 8'd0);
    check("mid_rst_lost",   {7'd0, lock_lost}, 8'd0);
    check("mid_rst_loss",   {4'd0, loss_cnt}, 8'd0);
    check("mid_rst_glitch", {4'd0, glitch_cnt}, 8'd0);
    push_exp(r + LW + 1,      SIG_LOCKED, 0, "post_rst_early");
    push_exp(r + LW + 2,      SIG_LOCKED, 1, "post_rst_rise");
    push_exp(r + LW + RH + 1, SIG_RSTN,   0, "post_rst_rstn_early");
    push_exp(r + LW + RH + 2, SIG_RSTN,   1, "post_rst_rstn_rise");
    ticks(28);

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Sits directly downstream of the PLL wrapper. Clocked by the PLL output clock, it qualifies the raw PLL lock indication and produces a filtered `locked` and a synchronous downstream reset (`rst_out_n`). It also keeps saturating event counters for lock losses and sub-threshold lock glitches. Lock glitch tolerance is needed because the PLL is built in irradiation-hardened mode, where single-event upsets can drop the lock flag for a few cycles.

## Interface
- `LOCK_WINDOW`, 16: consecutive synchronized-high cycles of `locked_raw` required to declare lock; ≥1.
- `UNLOCK_FILTER`, 4: consecutive synchronized-low cycles required to declare loss; ≥1.
- `RST_HOLD`, 8: cycles `rst_out_n` stays low after `locked` rises; ≥1.
- `CNT_W`, 8: width of the event counters.
- `inclk0`  in  1  clock: the PLL output clock c0.
- `reset_n`  in  1  reset, synchronous, active-low.
- `locked_raw`  in  1  raw PLL lock flag, asynchronous to `inclk0`.
- `clear_cnt`  in  1  synchronous clear of both counters.
- `locked`  out  1  filtered lock status.
- `rst_out_n`  out  1  synchronous active-low reset for downstream logic.
- `lock_lost`  out  1  one-cycle pulse on a declared lock loss.
- `loss_cnt`  out  CNT_W  saturating count of declared losses.
- `glitch_cnt`  out  CNT_W  saturating count of filtered low runs.

## Operation
- Reset values while `reset_n` is low at an edge:
  - `locked`=0, `rst_out_n`=0, `lock_lost`=0, both counters=0.
  - Both synchronizer flops=0; state=UNLOCKED.
  - Reset overrides any state, including mid-window and mid-hold.
- Synchronizer:
  - `locked_raw` passes through 2 flops and produces `sync`.
  - Only `sync` is used by the FSM.
- FSM states: UNLOCKED, ACQUIRE, HOLD_RST, LOCKED.
  - UNLOCKED: `sync`=1 → ACQUIRE; window count = 1.
  - ACQUIRE, `sync`=0 → UNLOCKED, window cleared; no counter changes.
  - ACQUIRE, `sync`=1 with count reaching `LOCK_WINDOW` → HOLD_RST; `locked`←1.
  - `LOCK_WINDOW`=1: UNLOCKED goes directly to HOLD_RST.
  - HOLD_RST: after `RST_HOLD` cycles → LOCKED; `rst_out_n`←1.
  - HOLD_RST and LOCKED share the loss filter. A low-run counter counts consecutive `sync`=0 cycles.
  - Low run reaching `UNLOCK_FILTER` → UNLOCKED. `locked`←0, `rst_out_n`←0, `lock_lost`=1 for that one cycle, `loss_cnt`+1.
  - Low run of length 1..`UNLOCK_FILTER`−1 ended by `sync`=1 → `glitch_cnt`+1; low-run counter cleared; state unchanged.
  - During a glitch, HOLD_RST keeps counting its hold.
  - `UNLOCK_FILTER`=1: any low is a loss; `glitch_cnt` never increments.
- Counters:
  - Both saturate at 2^CNT_W−1.
  - `clear_cnt` zeroes both counters.
  - If an event coincides with `clear_cnt`, that counter loads 1.
- Widths:
  - Window, hold, and filter counters are sized by `$clog2(PARAM+1)`.
  - No wrap-around is permitted in any counter.

## Timing
- Let k be the first edge sampling `locked_raw`=1, with `locked_raw` held high.
  - `sync` is high after edge k+1.
  - `locked` is high after edge k+1+`LOCK_WINDOW`.
  - `rst_out_n` is high after edge k+1+`LOCK_WINDOW`+`RST_HOLD`.
- Let j be the first edge sampling `locked_raw`=0, with `locked_raw` held low.
  - `locked`, `rst_out_n`, and the `lock_lost` pulse change after edge j+1+`UNLOCK_FILTER`.
  - `loss_cnt` updates on the same edge.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `pll_mon_pkg` holds:
  - the state enum `pll_mon_state_t`;
  - default constants `PLL_MON_LOCK_WINDOW`, `PLL_MON_UNLOCK_FILTER`, `PLL_MON_RST_HOLD`, `PLL_MON_CNT_W`.
- Sub-module `pll_lock_sync`: 2-flop synchronizer with synchronous active-low reset, reusable for other PLL status lines.

## Test plan
Bench parameters: `LOCK_WINDOW`=16, `UNLOCK_FILTER`=4, `RST_HOLD`=8, `CNT_W`=4.
- Release reset, then `locked_raw` high from edge 0 → `locked` rises after edge 17, `rst_out_n` after edge 25, `lock_lost` never asserts.
- `locked_raw` high for edges 0–9, low at 10, high again from 20 → `locked` stays 0 through edge 30, rises after edge 37; counters stay 0.
- While LOCKED, `locked_raw` low for 3 edges → `locked`=1 throughout, `glitch_cnt`=1, `loss_cnt`=0.
- While LOCKED, `locked_raw` low held from edge j → after edge j+5: `locked`=0, `rst_out_n`=0, one-cycle `lock_lost`, `loss_cnt`=1. Raising again relocks with full window.
- Loss-count saturation and clear:
  - 17 forced losses → `loss_cnt`=15 (saturated).
  - `clear_cnt` pulse → 0.
  - `clear_cnt` coincident with a loss → 1.
- `reset_n` low for one edge r while LOCKED with `locked_raw` high → all outputs 0 after edge r. After release, `locked` rises after edge r+18.
